// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding its 64-bit result in HI/LO.
// Latency: result lands in HI/LO 32 edges after the start edge; done pulses the cycle after.
// No backpressure: start is taken only in IDLE, and the control unit stalls on busy.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        whi_i,
  input  logic        wlo_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        bz_q, bz_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_div, is_signed;
  logic [32:0] msum;
  logic [32:0] rsh;
  logic [33:0] rdiff;
  logic [63:0] acc_nxt;
  logic [63:0] prod_res;
  logic [31:0] quo_res, rem_res;

  // Multiply keeps the shifting multiplier in mb_q; divide shifts the dividend out of ma_q.
  always_comb begin
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    msum      = {1'b0, acc_q[63:32]} + (mb_q[0] ? {1'b0, ma_q} : 33'd0);
    rsh       = {acc_q[63:32], ma_q[31]};
    rdiff     = {1'b0, rsh} - {2'b00, mb_q};
    if (is_div) begin
      acc_nxt = rdiff[33] ? {rsh[31:0], acc_q[30:0], 1'b0}
                          : {rdiff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_nxt = {msum, acc_q[31:1]};
    end
    prod_res = (is_signed && qneg_q) ? -acc_nxt : acc_nxt;
    // A zero divisor leaves remainder = |a|, so the signed fix-up restores the original a.
    quo_res  = bz_q ? 32'hFFFF_FFFF
             : ((is_signed && qneg_q) ? -acc_nxt[31:0] : acc_nxt[31:0]);
    rem_res  = (is_signed && rneg_q) ? -acc_nxt[63:32] : acc_nxt[63:32];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (state_q != S_RUN) begin
      if (whi_i) hi_d = wdata_i;
      if (wlo_i) lo_d = wdata_i;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          ma_d    = (~op_i[0] && a_i[31]) ? -a_i : a_i;
          mb_d    = (~op_i[0] && b_i[31]) ? -b_i : b_i;
          qneg_d  = a_i[31] ^ b_i[31];
          rneg_d  = a_i[31];
          bz_d    = (b_i == 32'd0);
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 5'd1;
        if (is_div) ma_d = {ma_q[30:0], 1'b0};
        else        mb_d = {1'b0, mb_q[31:1]};
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          if (is_div) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            hi_d = prod_res[63:32];
            lo_d = prod_res[31:0];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      ma_q    <= 32'd0;
      mb_q    <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        whi_i = 1'b0;
  logic        wlo_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  muldiv_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .whi_i(whi_i), .wlo_i(wlo_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_o) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Returns one cycle after the start edge with operands scrambled.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    tick();
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    tick();
    start_i = 1'b0;
    op_i    = 2'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy_o && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    start_op(op, a, b);
    wait_done(cyc);
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    tick();
    chk({tag, "_done_low"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int d0;

    repeat (2) tick();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    rst_i = 1'b0;

    run_op("multu_ovf",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("mult_wide",  2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_basic", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op("divu_zero",  2'b11, 32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zero",   2'b10, 32'hFFFF_FFFB, 32'h0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTLO / MTHI in IDLE
    tick();
    wlo_i = 1'b1; wdata_i = 32'h1234_5678;
    tick();
    wlo_i = 1'b0;
    chk("mtlo_idle", 64'(lo_o), 64'h1234_5678);
    whi_i = 1'b1; wdata_i = 32'hAAAA_0000;
    tick();
    whi_i = 1'b0;
    chk("mthi_idle", 64'(hi_o), 64'hAAAA_0000);

    // Ignored start and MTHI while running
    d0 = done_cnt;
    start_op(2'b01, 32'd6, 32'd7);
    repeat (10) tick();
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd3;
    whi_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    tick();
    start_i = 1'b0; whi_i = 1'b0;
    chk("mthi_run_hi", 64'(hi_o), 64'hAAAA_0000);
    chk("run_lo_hold", 64'(lo_o), 64'h1234_5678);
    wait_done(cyc);
    chk("busy_start_done", 64'(done_o), 64'd1);
    chk("busy_start_hi", 64'(hi_o), 64'd0);
    chk("busy_start_lo", 64'(lo_o), 64'd42);
    repeat (40) tick();
    chk("busy_start_ndone", 64'(done_cnt - d0), 64'd1);
    chk("busy_start_idle", 64'(busy_o), 64'd0);

    // start together with MTLO: write visible, then overwritten
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd4;
    wlo_i = 1'b1; wdata_i = 32'h55AA_55AA;
    tick();
    start_i = 1'b0; wlo_i = 1'b0;
    chk("start_mtlo_lo", 64'(lo_o), 64'h55AA_55AA);
    chk("start_mtlo_busy", 64'(busy_o), 64'd1);
    wait_done(cyc);
    chk("start_mtlo_cyc", 64'(cyc), 64'd32);
    chk("start_mtlo_res", 64'({hi_o, lo_o}), 64'd12);

    // Reset mid-operation
    tick();
    d0 = done_cnt;
    start_op(2'b01, 32'd9, 32'd9);
    repeat (15) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_hi", 64'(hi_o), 64'd0);
    chk("midrst_lo", 64'(lo_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    repeat (40) tick();
    chk("midrst_nodone", 64'(done_cnt - d0), 64'd0);
    run_op("post_rst", 2'b01, 32'd5, 32'd7, 32'd0, 32'd35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
